// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the instruction-memory address and registers the returned word into IF/ID.
// Latency: word at PC=A appears on instructionOut one edge after the RUN edge that sees A; branch-to-target is 2 edges.
// Backpressure: stall freezes PC and IF/ID (not in HALT); a branch overrides stall and squashes the wrong-path word.
module instruction_fetch_unit #(
    parameter int PC_WIDTH    = 16,
    parameter int INSTR_WIDTH = 16,
    parameter int PC_STEP     = 2,
    parameter int RESET_PC    = 0,
    parameter int HALT_WORD   = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    programCounter,
    input  logic [INSTR_WIDTH-1:0] instructionIn,
    input  logic                   stall,
    input  logic                   branchTaken,
    input  logic [PC_WIDTH-1:0]    branchTarget,
    output logic [INSTR_WIDTH-1:0] instructionOut,
    output logic [PC_WIDTH-1:0]    pcOut,
    output logic                   validOut,
    output logic                   halted,
    output logic [15:0]            fetchCount
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PC_WIDTH-1:0]      pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic [PC_WIDTH-1:0]      pc_out_q, pc_out_d;
    logic                     valid_q, valid_d;
    logic                     halted_q, halted_d;
    logic [15:0]              count_q, count_d;

    // Next-state and IF/ID update: branch beats stall, stall beats the state action.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;

        if (branchTaken) begin
            // Instructions live at even addresses, so the low target bit is dropped.
            pc_d     = {branchTarget[PC_WIDTH-1:1], 1'b0};
            instr_d  = '0;
            valid_d  = 1'b0;
            halted_d = 1'b0;
            state_d  = RUN;
        end else begin
            case (state_q)
                BOOT: begin
                    // One idle cycle lets the memory present its reset-loaded contents.
                    valid_d = 1'b0;
                    state_d = RUN;
                end
                RUN: begin
                    if (!stall) begin
                        if (instructionIn == INSTR_WIDTH'(HALT_WORD)) begin
                            // The halt word is never delivered as a valid instruction.
                            instr_d  = '0;
                            valid_d  = 1'b0;
                            pc_out_d = pc_q;
                            halted_d = 1'b1;
                            state_d  = HALT;
                        end else begin
                            instr_d  = instructionIn;
                            pc_out_d = pc_q;
                            valid_d  = 1'b1;
                            pc_d     = pc_q + PC_WIDTH'(PC_STEP);
                            if (count_q != 16'hFFFF) begin
                                count_d = count_q + 16'd1;
                            end
                        end
                    end
                end
                HALT: begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    // State and IF/ID registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= BOOT;
            pc_q     <= PC_WIDTH'(RESET_PC);
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign programCounter = pc_q;
    assign instructionOut = instr_q;
    assign pcOut          = pc_out_q;
    assign validOut       = valid_q;
    assign halted         = halted_q;
    assign fetchCount     = count_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end fetch stage and read-side master of the 16-bit instruction memory.
- Drives the byte address `programCounter` and consumes the combinationally returned instruction word in the same cycle.
- Registers the word, with its PC, into the IF/ID pipeline register for decode.
- Handles stalls, taken-branch redirects, halt-word detection and a fetch counter.

Parameters:
PC_WIDTH, 16, width of programCounter/branchTarget/pcOut
INSTR_WIDTH, 16, instruction word width
PC_STEP, 2, byte increment per sequential fetch (instructions sit at even addresses)
RESET_PC, 0, PC value loaded on reset
HALT_WORD, 0, instruction encoding that terminates fetch

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
programCounter  output  PC_WIDTH  fetch address to instruction memory
instructionIn  input  INSTR_WIDTH  instruction returned combinationally for programCounter
stall  input  1  hazard hold from decode/execute; freezes PC and IF/ID
branchTaken  input  1  redirect request from execute, single-cycle pulse
branchTarget  input  PC_WIDTH  redirect address, valid when branchTaken=1
instructionOut  output  INSTR_WIDTH  IF/ID instruction register
pcOut  output  PC_WIDTH  address of instructionOut
validOut  output  1  instructionOut is a real instruction (0 = bubble)
halted  output  1  fetch stopped on HALT_WORD
fetchCount  output  16  number of valid instructions delivered, saturating

Behaviour:
- Reset (reset=0, async): programCounter=RESET_PC, instructionOut=0, pcOut=0, validOut=0, halted=0, fetchCount=0, state=BOOT. All outputs are registered; none depends combinationally on inputs.
- States: BOOT, RUN, HALT.
- Per-edge priority: branchTaken > stall > state action.
- BOOT: lasts exactly one cycle after reset release, giving the memory its reset-loaded contents. PC is held, validOut=0. Next state is RUN.
- RUN, no stall, no branch, instructionIn != HALT_WORD:
  - instructionOut<=instructionIn, pcOut<=programCounter, validOut<=1.
  - programCounter<=programCounter+PC_STEP, modulo 2^PC_WIDTH (0xFFFE wraps to 0x0000).
  - fetchCount<=fetchCount+1, saturating at 0xFFFF.
- RUN, instructionIn == HALT_WORD:
  - instructionOut<=0, validOut<=0, pcOut<=programCounter.
  - PC is held; halted<=1; state<=HALT.
  - fetchCount is unchanged; the halt word is never delivered as valid.
- stall=1 (RUN or BOOT, no branch): PC, instructionOut, pcOut, validOut and fetchCount all hold. Halt detection is suppressed while stalled.
- branchTaken=1 (any state except reset):
  - programCounter<={branchTarget[PC_WIDTH-1:1],1'b0}; an odd target is forced even.
  - instructionOut<=0, validOut<=0 (squash the wrong-path word), halted<=0, state<=RUN. This overrides a simultaneous stall.
  - A branch in BOOT skips the remainder of BOOT.
  - A branch in HALT resumes fetch, because halt detection is speculative.
- HALT: PC, pcOut and fetchCount hold. validOut=0, halted=1. stall is ignored. Only branchTaken or reset leave this state.
- Latency: an instruction presented at PC=A appears on instructionOut/pcOut one clock edge after the edge that sees PC=A in RUN. Branch-to-first-valid-target-instruction is 2 edges.
- Reset asserted mid-operation clears everything immediately, regardless of clock.

Test Plan:
- Reset, release, run 3 cycles with the standard program loaded: edge 1 is BOOT (validOut=0, PC=0x0000). Edge 2 gives instructionOut=0x012F, pcOut=0x0000, PC=0x0002. Edge 3 gives 0x012E, pcOut=0x0002, fetchCount=2.
- Free run to the halt word at address 0x0032: after 0x0CDF (pcOut=0x0030) comes validOut=0, halted=1, PC stays 0x0032, fetchCount=25. It stays frozen for 10 more cycles, even with stall toggling.
- Assert stall for 3 cycles while PC=0x0008: PC remains 0x0008 and instructionOut stays 0x032D with validOut=1. After release, the next edge gives instructionOut=0x0561, pcOut=0x0008.
- Pulse branchTaken with branchTarget=0x0024 while stall=1 at PC=0x0016: the next edge gives validOut=0, PC=0x0024. The following edge gives instructionOut=0x8890, pcOut=0x0024.
- In HALT, pulse branchTaken with branchTarget=0x0031: PC=0x0030, halted=0. The next edge gives instructionOut=0x0CDF, then the design halts again at 0x0032.
- Branch to 0xFFFE with the memory returning 0x1111: the next fetch is pcOut=0xFFFE, PC wraps to 0x0000. Asserting reset mid-run immediately forces PC=0 and validOut=0, and BOOT repeats.
